// File: rtl/vec_loader_pkg.sv
// Shared defaults and state encoding for the vector loader that feeds dotprod.
package vec_loader_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 1 << 20;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_OUT    = 3'd5
  } state_e;

endpackage

// File: rtl/vec_loader_if.sv
// Element-pair input stream and result output handshake of the vector loader.
interface vec_loader_if #(
  parameter int unsigned DATA_W = 32
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_a;
  logic [DATA_W-1:0] s_b;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_result;

  // Environment side: produces element pairs, consumes the result.
  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_result
  );

  // Loader side.
  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_result
  );

endinterface

// File: rtl/vec_loader.sv
// Streams element pairs into the a/b RAMs, kicks dotprod, and returns its result
// over a valid/ready handshake with a bounded wait for completion.
import vec_loader_pkg::*;

module vec_loader #(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [31:0]       cfg_n,
  vec_loader_if.slave       io,
  output logic              ram_init,
  output logic [DATA_W-1:0] a_ram_in,
  output logic [DATA_W-1:0] b_ram_in,
  output logic [ADDR_W-1:0] a_addr_in,
  output logic [ADDR_W-1:0] b_addr_in,
  output logic              start_sig,
  output logic [31:0]       n,
  input  logic              done_flag,
  input  logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              err
);

  localparam int unsigned BEAT_W = ADDR_W + 1;
  localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [32:0] MAX_N  = 33'(1) << ADDR_W;

  localparam logic [2:0] IDLE   = S_IDLE;
  localparam logic [2:0] LOAD   = S_LOAD;
  localparam logic [2:0] SETTLE = S_SETTLE;
  localparam logic [2:0] START  = S_START;
  localparam logic [2:0] WAIT   = S_WAIT;
  localparam logic [2:0] OUT    = S_OUT;

  logic [2:0]        state_q,    state_d;
  logic [BEAT_W-1:0] beat_q,     beat_d;
  logic [TO_W-1:0]   to_q,       to_d;
  logic [31:0]       n_q,        n_d;
  logic              s_ready_q,  s_ready_d;
  logic              ram_init_q, ram_init_d;
  logic [DATA_W-1:0] a_ram_q,    a_ram_d;
  logic [DATA_W-1:0] b_ram_q,    b_ram_d;
  logic [ADDR_W-1:0] a_addr_q,   a_addr_d;
  logic [ADDR_W-1:0] b_addr_q,   b_addr_d;
  logic              start_q,    start_d;
  logic              m_valid_q,  m_valid_d;
  logic [DATA_W-1:0] m_result_q, m_result_d;
  logic              busy_q,     busy_d;
  logic              err_q,      err_d;

  logic cfg_ok_c;
  logic accept_c;
  logic last_beat_c;

  assign cfg_ok_c    = (cfg_n != 32'd0) && ({1'b0, cfg_n} <= MAX_N);
  assign accept_c    = io.s_valid && s_ready_q;
  assign last_beat_c = (beat_q == BEAT_W'(n_q - 32'd1));

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    to_d       = to_q;
    n_d        = n_q;
    ram_init_d = ram_init_q;
    a_ram_d    = a_ram_q;
    b_ram_d    = b_ram_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    m_result_d = m_result_q;
    start_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_req) begin
          if (cfg_ok_c) begin
            n_d     = cfg_n;
            beat_d  = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept_c) begin
          a_addr_d   = ADDR_W'(beat_q);
          b_addr_d   = ADDR_W'(beat_q);
          a_ram_d    = io.s_a;
          b_ram_d    = io.s_b;
          ram_init_d = 1'b1;
          beat_d     = beat_q + BEAT_W'(1);
          if (last_beat_c) state_d = SETTLE;
        end
      end
      SETTLE: begin
        ram_init_d = 1'b1;
        state_d    = START;
      end
      START: begin
        ram_init_d = 1'b0;
        start_d    = 1'b1;
        to_d       = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (done_flag) begin
          m_result_d = result;
          state_d    = OUT;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      OUT: begin
        if (io.m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the state being entered.
    s_ready_d = (state_d == LOAD);
    m_valid_d = (state_d == OUT);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      to_q       <= '0;
      n_q        <= '0;
      s_ready_q  <= 1'b0;
      ram_init_q <= 1'b0;
      a_ram_q    <= '0;
      b_ram_q    <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      start_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_result_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      to_q       <= to_d;
      n_q        <= n_d;
      s_ready_q  <= s_ready_d;
      ram_init_q <= ram_init_d;
      a_ram_q    <= a_ram_d;
      b_ram_q    <= b_ram_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      start_q    <= start_d;
      m_valid_q  <= m_valid_d;
      m_result_q <= m_result_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign io.s_ready  = s_ready_q;
  assign io.m_valid  = m_valid_q;
  assign io.m_result = m_result_q;
  assign ram_init    = ram_init_q;
  assign a_ram_in    = a_ram_q;
  assign b_ram_in    = b_ram_q;
  assign a_addr_in   = a_addr_q;
  assign b_addr_in   = b_addr_q;
  assign start_sig   = start_q;
  assign n           = n_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vec_loader.sv
// Directed self-checking bench for vec_loader; the bench plays the dotprod side.
module tb_vec_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 16;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          load_req = 1'b0;
  logic [31:0]   cfg_n    = '0;
  logic          ram_init;
  logic [DW-1:0] a_ram_in;
  logic [DW-1:0] b_ram_in;
  logic [AW-1:0] a_addr_in;
  logic [AW-1:0] b_addr_in;
  logic          start_sig;
  logic [31:0]   n;
  logic          done_flag = 1'b0;
  logic [DW-1:0] result    = '0;
  logic          busy;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vec_loader_if #(.DATA_W(DW)) bus ();

  vec_loader #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .cfg_n     (cfg_n),
    .io        (bus),
    .ram_init  (ram_init),
    .a_ram_in  (a_ram_in),
    .b_ram_in  (b_ram_in),
    .a_addr_in (a_addr_in),
    .b_addr_in (b_addr_in),
    .start_sig (start_sig),
    .n         (n),
    .done_flag (done_flag),
    .result    (result),
    .busy      (busy),
    .err       (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [31:0] len);
    load_req = 1'b1;
    cfg_n    = len;
    tick();
    load_req = 1'b0;
  endtask

  // One accepted beat, then check the RAM write presented the next cycle.
  task automatic send_beat(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    tick();
    bus.s_valid = 1'b0;
    chk("beat_a_addr", 64'(a_addr_in), 64'(k));
    chk("beat_b_addr", 64'(b_addr_in), 64'(k));
    chk("beat_a_data", 64'(a_ram_in), 64'(a));
    chk("beat_b_data", 64'(b_ram_in), 64'(b));
    chk("beat_ram_init", 64'(ram_init), 64'd1);
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (start_sig !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("start_seen", 64'(start_sig), 64'd1);
    chk("start_ram_init", 64'(ram_init), 64'd0);
  endtask

  task automatic finish_txn(input logic [DW-1:0] res);
    done_flag = 1'b1;
    result    = res;
    tick();
    done_flag = 1'b0;
    result    = '0;
    chk("out_m_valid", 64'(bus.m_valid), 64'd1);
    chk("out_m_result", 64'(bus.m_result), 64'(res));
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("out_done_m_valid", 64'(bus.m_valid), 64'd0);
    chk("out_done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int  c;
    int  i;
    bit  mv_seen;

    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.m_ready = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_ram_init", 64'(ram_init), 64'd0);
    chk("rst_start", 64'(start_sig), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_n", 64'(n), 64'd0);
    chk("rst_m_result", 64'(bus.m_result), 64'd0);
    chk("rst_addr", 64'(a_addr_in), 64'd0);
    rst = 1'b0;
    tick();

    // Four beats with s_valid held, dotprod returns 100
    start_load(32'd4);
    chk("l4_s_ready", 64'(bus.s_ready), 64'd1);
    chk("l4_busy", 64'(busy), 64'd1);
    chk("l4_n", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++) send_beat(k, DW'(2 * k + 1), DW'(2 * k + 2));
    chk("l4_s_ready_after_last", 64'(bus.s_ready), 64'd0);
    tick();
    chk("l4_settle_ram_init", 64'(ram_init), 64'd1);
    chk("l4_settle_no_start", 64'(start_sig), 64'd0);
    wait_start(c);
    chk("l4_latency", 64'(c + 2), 64'd3);
    done_flag = 1'b0;
    tick();
    chk("l4_start_one_cycle", 64'(start_sig), 64'd0);
    finish_txn(DW'(100));

    // Three beats with s_valid toggled every other cycle
    start_load(32'd3);
    for (int k = 0; k < 3; k++) begin
      send_beat(k, DW'(16 + k), DW'(32 + k));
      bus.s_a = DW'(99);
      bus.s_b = DW'(98);
      tick();
      chk("tg_hold_addr", 64'(a_addr_in), 64'(k));
      chk("tg_hold_data", 64'(a_ram_in), 64'(16 + k));
      chk("tg_ram_init", 64'(ram_init), 64'd1);
    end
    wait_start(c);
    chk("tg_latency", 64'(c + 2), 64'd3);
    finish_txn(DW'(32'h55));

    // Illegal lengths: zero and one past the maximum
    start_load(32'd0);
    chk("z_err", 64'(err), 64'd1);
    chk("z_busy", 64'(busy), 64'd0);
    chk("z_s_ready", 64'(bus.s_ready), 64'd0);
    tick();
    chk("z_err_pulse", 64'(err), 64'd0);
    start_load(32'd65537);
    chk("big_err", 64'(err), 64'd1);
    chk("big_busy", 64'(busy), 64'd0);
    chk("big_s_ready", 64'(bus.s_ready), 64'd0);
    tick();
    chk("big_err_pulse", 64'(err), 64'd0);

    // Maximum length is accepted
    start_load(32'd65536);
    chk("max_busy", 64'(busy), 64'd1);
    chk("max_err", 64'(err), 64'd0);
    chk("max_n", 64'(n), 64'd65536);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset in the middle of a load, then a clean 2-beat load
    start_load(32'd5);
    send_beat(0, DW'(7), DW'(8));
    send_beat(1, DW'(9), DW'(10));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ml_ram_init", 64'(ram_init), 64'd0);
    chk("ml_s_ready", 64'(bus.s_ready), 64'd0);
    chk("ml_busy", 64'(busy), 64'd0);
    start_load(32'd2);
    send_beat(0, DW'(10), DW'(20));
    send_beat(1, DW'(30), DW'(40));
    wait_start(c);
    finish_txn(DW'(1400));

    // dotprod never completes: timeout after 16 cycles in WAIT
    start_load(32'd1);
    send_beat(0, DW'(3), DW'(4));
    wait_start(c);
    i = 0;
    mv_seen = 1'b0;
    while (err !== 1'b1 && i < 40) begin
      tick();
      i++;
      if (bus.m_valid === 1'b1) mv_seen = 1'b1;
    end
    chk("to_cycles", 64'(i), 64'd16);
    chk("to_m_valid_seen", 64'(mv_seen), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    done_flag = 1'b1;
    result    = DW'(123);
    tick();
    done_flag = 1'b0;
    chk("idle_done_ignored", 64'(bus.m_valid), 64'd0);
    chk("idle_done_busy", 64'(busy), 64'd0);

    // Consumer stalls in OUT while load_req is pulsed
    start_load(32'd2);
    send_beat(0, DW'(1), DW'(1));
    send_beat(1, DW'(2), DW'(2));
    wait_start(c);
    done_flag = 1'b1;
    result    = DW'(32'hABCD);
    tick();
    done_flag = 1'b0;
    result    = '0;
    for (int k = 0; k < 10; k++) begin
      load_req = (k == 3);
      cfg_n    = 32'd3;
      tick();
      chk("stall_m_valid", 64'(bus.m_valid), 64'd1);
      chk("stall_m_result", 64'(bus.m_result), 64'h0000_ABCD);
    end
    load_req    = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    load_req    = 1'b0;
    bus.m_ready = 1'b0;
    chk("hs_m_valid", 64'(bus.m_valid), 64'd0);
    chk("hs_busy", 64'(busy), 64'd0);
    tick();
    chk("hs_load_ignored_busy", 64'(busy), 64'd0);
    chk("hs_load_ignored_s_ready", 64'(bus.s_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_loader.md
VEC_LOADER -- requirements
Module: vec_loader

Interface
- REQ-001 Parameter DATA_W, default 32: element and result width.
- REQ-002 Parameter ADDR_W, default 16: RAM address width; maximum vector length is 2^ADDR_W.
- REQ-003 Parameter TIMEOUT, default 2^20: maximum number of cycles to wait for done_flag.
- REQ-004 Port list (name, direction, width, meaning):
  - clk  in  1  single clock; all logic on rising edge.
  - rst  in  1  synchronous, active-high reset.
  - load_req  in  1  one-cycle request to begin a load; sampled in IDLE only.
  - cfg_n  in  32  vector length; captured on the accepted load_req.
  - s_valid  in  1  input element pair valid.
  - s_ready  out  1  loader can accept a pair this cycle.
  - s_a  in  DATA_W  element of vector a.
  - s_b  in  DATA_W  element of vector b.
  - ram_init  out  1  RAM ports driven by the loader.
  - a_ram_in  out  DATA_W  write data, RAM a.
  - b_ram_in  out  DATA_W  write data, RAM b.
  - a_addr_in  out  ADDR_W  write address, RAM a.
  - b_addr_in  out  ADDR_W  write address, RAM b.
  - start_sig  out  1  one-cycle start pulse to dotprod.
  - n  out  32  vector length presented to dotprod.
  - done_flag  in  1  dotprod completion.
  - result  in  DATA_W  dotprod result.
  - m_valid  out  1  result available on m_result.
  - m_ready  in  1  consumer accepts the result.
  - m_result  out  DATA_W  latched result.
  - busy  out  1  high in every state except IDLE.
  - err  out  1  one-cycle error pulse.

Function
- REQ-005 The block SHALL implement an FSM with states IDLE, LOAD, SETTLE, START, WAIT and OUT; all outputs SHALL be registered.
- REQ-006 In IDLE, load_req=1 with 1<=cfg_n<=2^ADDR_W SHALL capture cfg_n into n, clear the beat counter and enter LOAD.
- REQ-007 In IDLE, load_req=1 with cfg_n=0 or cfg_n>2^ADDR_W SHALL pulse err for one cycle and remain in IDLE.
- REQ-008 s_ready SHALL be 1 only in LOAD; a beat is accepted when s_valid and s_ready are both 1 on a rising edge.
- REQ-009 On accepting beat k (0-based), the next cycle SHALL show a_addr_in=b_addr_in=k, a_ram_in=s_a, b_ram_in=s_b and ram_init=1; the RAM writes on the following falling edge.
- REQ-010 ram_init SHALL be 1 continuously from the first accepted beat through SETTLE; address and data SHALL hold their last value on cycles with no accepted beat.
- REQ-011 Accepting beat n-1 SHALL move the FSM to SETTLE, with s_ready=0 on the next cycle.
- REQ-012 SETTLE SHALL last exactly one cycle with ram_init=1, after which ram_init falls and the FSM enters START.
- REQ-013 START SHALL assert start_sig for exactly one cycle with ram_init=0, then enter WAIT.
- REQ-014 In WAIT, done_flag=1 SHALL latch result into m_result and enter OUT; done_flag in any other state SHALL be ignored.
- REQ-015 In WAIT, reaching TIMEOUT cycles without done_flag SHALL pulse err and return to IDLE without asserting m_valid.
- REQ-016 In OUT, m_valid SHALL be 1 with m_result stable until m_valid and m_ready are both 1, then m_valid SHALL fall and the FSM SHALL enter IDLE.
- REQ-017 load_req outside IDLE SHALL be ignored, and the same-cycle load_req in the handshake cycle of REQ-016 SHALL also be ignored.
- REQ-018 The beat counter SHALL be ADDR_W+1 bits wide, so that n=2^ADDR_W writes addresses 0 to 2^ADDR_W-1 with no wrap before completion.
- REQ-019 Total latency from the last accepted beat to start_sig SHALL be 3 cycles.

Reset
- REQ-020 When rst=1, the FSM SHALL enter IDLE on the next rising edge regardless of current state, including mid-LOAD and mid-WAIT.
- REQ-021 Reset values SHALL be: s_ready, ram_init, start_sig, m_valid, busy and err = 0; n, m_result, addresses and data = 0; beat and timeout counters = 0.
- REQ-022 A partially loaded RAM after reset SHALL NOT be protected; the next load overwrites it.

Structure
- REQ-023 Package vec_loader_pkg SHALL hold the state enum typedef, the DATA_W/ADDR_W defaults and the TIMEOUT default.
- REQ-024 The block SHALL be a single module with no sub-module; it sits upstream of dotprod and drives the existing ram_init, *_ram_in, *_addr_in, start_sig and n ports of top.

Verification
- REQ-025 cfg_n=4, pairs (1,2),(3,4),(5,6),(7,8) with s_valid held high -> addresses 0..3 written, start_sig exactly 3 cycles after the last beat, dotprod returns 100, m_result=100.
- REQ-026 cfg_n=3 with s_valid toggled every other cycle -> exactly 3 writes at addresses 0,1,2 and ram_init high continuously through SETTLE.
- REQ-027 cfg_n=0, then cfg_n=65537 -> err pulses once for each request, busy stays 0, s_ready stays 0.
- REQ-028 rst asserted after 2 of 5 beats -> next cycle ram_init=0, s_ready=0, busy=0; a new load with cfg_n=2 completes normally.
- REQ-029 done_flag held low with TIMEOUT=16 -> err pulses 16 cycles after entering WAIT, FSM returns to IDLE, m_valid never asserted.
- REQ-030 m_ready held low for 10 cycles in OUT, with load_req pulsed during that time -> m_result stable, load_req ignored, IDLE entered on the first m_ready.
